// File: rtl/servo_angle_sequencer.sv
// Servo angle sequencer: debounced preset keys pick a target angle, and the
// commanded angle ramps toward it by STEP degrees per PWM frame, then settles.
module servo_angle_sequencer #(
    parameter int DEBOUNCE_CYC  = 1_000_000,
    parameter int STEP          = 3,
    parameter int SETTLE_FRAMES = 10,
    parameter int INIT_ANGLE    = 135
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic [6:0] key,
    input  logic       frame_done,
    output logic [8:0] angle,
    output logic [8:0] target,
    output logic       busy,
    output logic       done
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [9:0]       STEP_W10 = 10'(STEP);
    localparam logic [8:0]       STEP_W9  = 9'(STEP);
    localparam logic [8:0]       INIT_V   = 9'(INIT_ANGLE);
    localparam logic [7:0]       SETTLE_V = 8'(SETTLE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    function automatic logic [8:0] key_angle(input logic [2:0] idx);
        logic [8:0] a;
        case (idx)
            3'd0:    a = 9'd0;
            3'd1:    a = 9'd45;
            3'd2:    a = 9'd90;
            3'd3:    a = 9'd135;
            3'd4:    a = 9'd180;
            3'd5:    a = 9'd30;
            3'd6:    a = 9'd60;
            default: a = 9'd0;
        endcase
        return a;
    endfunction

    state_e     state_q, state_d;
    logic [6:0] meta_q, sync_q;
    logic [6:0] press_s;
    logic [8:0] angle_q, angle_d;
    logic [8:0] target_q, target_d;
    logic [7:0] settle_q, settle_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       press_valid_s;
    logic [2:0] press_idx_s;
    logic [8:0] new_target_s;
    logic [8:0] stepped_s;
    logic [9:0] diff_s;
    logic       up_s;
    logic       settle_last_s;

    // Two-flop synchronizer on the raw key levels
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 7'd0;
            sync_q <= 7'd0;
        end else begin
            meta_q <= key;
            sync_q <= meta_q;
        end
    end

    for (genvar i = 0; i < 7; i++) begin : g_deb
        logic [CNT_W-1:0] cnt_q;
        logic             fired_q;
        logic             press_q;

        // Debounce counter; fired_q blocks re-triggering until the key reads low
        always_ff @(posedge sclk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                fired_q <= 1'b0;
                press_q <= 1'b0;
            end else if (!sync_q[i]) begin
                cnt_q   <= '0;
                fired_q <= 1'b0;
                press_q <= 1'b0;
            end else if (fired_q) begin
                press_q <= 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                fired_q <= 1'b1;
                press_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                press_q <= 1'b0;
            end
        end

        assign press_s[i] = press_q;
    end

    // Priority encoder: lowest key index wins
    always_comb begin
        press_valid_s = 1'b1;
        press_idx_s   = 3'd0;
        casez (press_s)
            7'b??????1: press_idx_s = 3'd0;
            7'b?????10: press_idx_s = 3'd1;
            7'b????100: press_idx_s = 3'd2;
            7'b???1000: press_idx_s = 3'd3;
            7'b??10000: press_idx_s = 3'd4;
            7'b?100000: press_idx_s = 3'd5;
            7'b1000000: press_idx_s = 3'd6;
            default:    press_valid_s = 1'b0;
        endcase
        new_target_s = key_angle(press_idx_s);
    end

    // One ramp step toward the latched target; snaps to target when within STEP
    always_comb begin
        if ({1'b0, target_q} >= {1'b0, angle_q}) begin
            diff_s = {1'b0, target_q} - {1'b0, angle_q};
            up_s   = 1'b1;
        end else begin
            diff_s = {1'b0, angle_q} - {1'b0, target_q};
            up_s   = 1'b0;
        end
        if (diff_s <= STEP_W10) begin
            stepped_s = target_q;
        end else if (up_s) begin
            stepped_s = angle_q + STEP_W9;
        end else begin
            stepped_s = angle_q - STEP_W9;
        end
        settle_last_s = (settle_q == (SETTLE_V - 8'd1));
    end

    // State register
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a press always overrides frame-driven transitions
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (press_valid_s) begin
                    state_d = (new_target_s != angle_q) ? S_RAMP : S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RAMP: begin
                if (press_valid_s) begin
                    state_d = S_RAMP;
                end else if (frame_done && (stepped_s == target_q)) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_RAMP;
                end
            end
            S_HOLD: begin
                if (press_valid_s) begin
                    state_d = (new_target_s != angle_q) ? S_RAMP : S_HOLD;
                end else if (frame_done && settle_last_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        angle_d  = frame_done ? stepped_s : angle_q;
        target_d = press_valid_s ? new_target_s : target_q;
        settle_d = 8'd0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: settle_d = 8'd0;
            S_RAMP: settle_d = 8'd0;
            S_HOLD: begin
                if (press_valid_s) begin
                    settle_d = 8'd0;
                end else if (frame_done) begin
                    settle_d = settle_q + 8'd1;
                    done_d   = settle_last_s;
                end else begin
                    settle_d = settle_q;
                end
            end
            default: settle_d = 8'd0;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q  <= INIT_V;
            target_q <= INIT_V;
            settle_q <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            angle_q  <= angle_d;
            target_q <= target_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign angle  = angle_q;
    assign target = target_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_servo_angle_sequencer.sv
// Bench for servo_angle_sequencer: directed scenarios plus randomized key/frame
// traffic, checked against a frame-level behavioural model of the sequencer.
module tb_servo_angle_sequencer;

    localparam int DEB = 16;
    localparam int STP = 3;
    localparam int SET = 2;
    localparam int INI = 135;

    logic       sclk;
    logic       rst_n;
    logic [6:0] key;
    logic       frame_done;
    logic [8:0] angle;
    logic [8:0] target;
    logic       busy;
    logic       done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int key_ang [7] = '{0, 45, 90, 135, 180, 30, 60};

    // Model state: phase 0 = idle, 1 = moving, 2 = settling
    int m_angle, m_target, m_phase, m_settle;

    servo_angle_sequencer #(
        .DEBOUNCE_CYC (DEB),
        .STEP         (STP),
        .SETTLE_FRAMES(SET),
        .INIT_ANGLE   (INI)
    ) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .key       (key),
        .frame_done(frame_done),
        .angle     (angle),
        .target    (target),
        .busy      (busy),
        .done      (done)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int step_to(input int a, input int t);
        int d;
        d = (t > a) ? t - a : a - t;
        if (d <= STP) return t;
        return (t > a) ? a + STP : a - STP;
    endfunction

    function automatic void model_reset();
        m_angle  = INI;
        m_target = INI;
        m_phase  = 0;
        m_settle = 0;
    endfunction

    function automatic void model_press(input logic [6:0] mask);
        int idx;
        idx = -1;
        for (int i = 6; i >= 0; i--) if (mask[i]) idx = i;
        if (idx < 0) return;
        m_target = key_ang[idx];
        m_settle = 0;
        if (m_phase != 1) m_phase = (m_target != m_angle) ? 1 : 2;
    endfunction

    function automatic bit model_frame();
        bit d;
        d = 1'b0;
        m_angle = step_to(m_angle, m_target);
        if (m_phase == 1) begin
            if (m_angle == m_target) begin
                m_phase  = 2;
                m_settle = 0;
            end
        end else if (m_phase == 2) begin
            m_settle++;
            if (m_settle == SET) begin
                d       = 1'b1;
                m_phase = 0;
            end
        end
        return d;
    endfunction

    task automatic check_all(input string tag, input bit exp_done);
        check_val({tag, ".angle"},  angle,  m_angle);
        check_val({tag, ".target"}, target, m_target);
        check_val({tag, ".busy"},   busy,   (m_phase != 0));
        check_val({tag, ".done"},   done,   exp_done);
    endtask

    task automatic frame_cycle(input bit fd);
        bit exp_done;
        frame_done = fd;
        @(posedge sclk);
        #1;
        frame_done = 1'b0;
        exp_done = fd ? model_frame() : 1'b0;
        check_all(fd ? "frame" : "idle_cyc", exp_done);
    endtask

    task automatic press_keys(input logic [6:0] mask, input int hold);
        key = mask;
        repeat (hold) @(posedge sclk);
        #1;
        key = 7'd0;
        repeat (4) @(posedge sclk);
        #1;
        if (hold >= DEB) model_press(mask);
        check_all("press", 1'b0);
    endtask

    task automatic run_until_idle();
        for (int n = 0; n < 200 && m_phase != 0; n++) frame_cycle(1'b1);
        check_val("settled", m_phase, 0);
        frame_cycle(1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        key        = 7'd0;
        frame_done = 1'b0;
        model_reset();
        repeat (3) @(posedge sclk);
        #1;
        check_all("in_reset", 1'b0);
        rst_n = 1'b1;
        @(posedge sclk);
        #1;
        check_all("after_reset", 1'b0);

        // Short press is ignored; full press retargets to 90
        press_keys(7'b0000100, 10);
        press_keys(7'b0000100, 20);
        check_val("tgt90", target, 90);
        run_until_idle();
        check_val("at90", angle, 90);

        // Simultaneous key0+key4: key0 wins, ramp ends exactly on 0
        press_keys(7'b0010001, 22);
        check_val("tgt0", target, 0);
        run_until_idle();
        check_val("at0", angle, 0);

        // Retarget mid-ramp with direction reversals
        press_keys(7'b0010000, 22);
        for (int n = 0; n < 100 && m_angle != 123; n++) frame_cycle(1'b1);
        press_keys(7'b0000100, 22);
        frame_cycle(1'b1);
        check_val("rev120", angle, 120);
        press_keys(7'b0010000, 22);
        frame_cycle(1'b1);
        check_val("rev123", angle, 123);
        run_until_idle();
        check_val("at180", angle, 180);

        // Asynchronous reset in the middle of a ramp
        press_keys(7'b0000001, 22);
        repeat (3) frame_cycle(1'b1);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst", 1'b0);
        @(posedge sclk);
        #1;
        rst_n = 1'b1;
        @(posedge sclk);
        #1;

        // Press for the current angle: hold-only, angle never moves
        press_keys(7'b0001000, 22);
        check_val("hold_busy", busy, 1);
        run_until_idle();
        check_val("hold_angle", angle, 135);

        // Key held across a frame: exactly one press, so settling is not restarted
        key = 7'b0001000;
        repeat (22) @(posedge sclk);
        #1;
        model_press(7'b0001000);
        frame_cycle(1'b1);
        repeat (30) @(posedge sclk);
        #1;
        key = 7'd0;
        repeat (4) @(posedge sclk);
        #1;
        frame_cycle(1'b1);
        check_val("single_press_done", done, 1);
        frame_cycle(1'b0);

        // Randomized traffic, including frame_done held high for several cycles
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                press_keys(7'($urandom_range(1, 127)),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12)
                                                       : $urandom_range(18, 30));
            end else begin
                int k;
                k = $urandom_range(1, 6);
                for (int j = 0; j < k; j++) frame_cycle(1'b1);
                frame_cycle(1'b0);
            end
        end
        run_until_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
